lsu_ctrl: RTL

Load/store unit sitting directly upstream of the data memory in the single-cycle RV32I core. It converts a core load/store request (byte address, funct3, store data) into word-indexed memory accesses, and returns sign- or zero-extended load data. Sub-word stores are performed as read-modify-write with a full-word write, so neighbouring bytes are preserved. Accesses that straddle a word boundary are split into two back-to-back word accesses, with the core stalled for one cycle.

---
 rtl/lsu_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the RV32I core and a word-wide data memory.
// Sub-word stores are read-modify-write with a full-word write; accesses that
// cross a word boundary take two back-to-back word cycles (IDLE then SECOND).
module lsu_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_stall,
    output logic        o_err,
    output logic [15:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [1:0]  off_q;
    logic [15:0] w_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_buf_q, lo_buf_d;
    logic        latch_en;

    // Address bits above the 256 KiB window are deliberately not decoded.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[31:18];

    // Sign- or zero-extend a right-aligned 1/2/4-byte value.
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] f3);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   r = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Replace the byte lanes selected by m in old_w with those of new_w.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = m[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return r;
    endfunction

    // Field selection: live core inputs in IDLE, latched copies in SECOND.
    logic        in_second;
    logic [2:0]  f3_s;
    logic [1:0]  off_s;
    logic [31:0] wdata_s;
    logic [2:0]  nbytes;
    logic [3:0]  size_mask;
    logic        legal, split;
    logic [4:0]  lo_sh, hi_sh;
    logic [63:0] wide_data;
    logic [7:0]  wide_mask;

    assign in_second = (state_q == SECOND);
    assign f3_s      = in_second ? f3_q    : i_funct3;
    assign off_s     = in_second ? off_q   : i_addr[1:0];
    assign wdata_s   = in_second ? wdata_q : i_wdata;
    assign lo_sh     = {off_s, 3'b000};
    // (4-off)*8 modulo 32; off is never 0 on the second half of a split.
    assign hi_sh     = 5'd0 - lo_sh;

    // Decode access size and legality of the incoming request.
    always_comb begin
        nbytes    = 3'd4;
        size_mask = 4'b1111;
        case (f3_s[1:0])
            2'b00:   begin nbytes = 3'd1; size_mask = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; size_mask = 4'b0011; end
            default: begin nbytes = 3'd4; size_mask = 4'b1111; end
        endcase
        case (i_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !i_we;
            default:                legal = 1'b0;
        endcase
        split = (({1'b0, off_s} + nbytes) > 3'd4);
    end

    // Store data and lane mask spread across two words: [31:0]/[3:0] hit word w,
    // [63:32]/[7:4] hit word w+1.
    assign wide_data = {32'd0, wdata_s} << lo_sh;
    assign wide_mask = {4'd0, size_mask} << off_s;

    // Combinational memory/core outputs and next-state decision.
    always_comb begin
        o_rdata     = 32'd0;
        o_done      = 1'b0;
        o_stall     = 1'b0;
        o_err       = 1'b0;
        o_mem_addr  = 16'd0;
        o_mem_wdata = 32'd0;
        o_mem_bmask = 4'b0000;
        o_mem_wren  = 1'b0;
        state_d     = state_q;
        latch_en    = 1'b0;
        lo_buf_d    = i_mem_rdata >> lo_sh;
        if (!i_reset) begin
            if (in_second) begin
                state_d    = IDLE;
                o_mem_addr = w_q + 16'd1;
                o_done     = 1'b1;
                if (we_q) begin
                    o_mem_wren  = 1'b1;
                    o_mem_bmask = 4'b1111;
                    o_mem_wdata = merge_lanes(i_mem_rdata, wide_data[63:32], wide_mask[7:4]);
                end else begin
                    o_rdata = extend(lo_buf_q | (i_mem_rdata << hi_sh), f3_q);
                end
            end else if (i_req) begin
                if (!legal) begin
                    o_done = 1'b1;
                    o_err  = 1'b1;
                end else begin
                    o_mem_addr = i_addr[17:2];
                    if (i_we) begin
                        o_mem_wren  = 1'b1;
                        o_mem_bmask = 4'b1111;
                        o_mem_wdata = merge_lanes(i_mem_rdata, wide_data[31:0], wide_mask[3:0]);
                    end else if (!split) begin
                        o_rdata = extend(i_mem_rdata >> lo_sh, i_funct3);
                    end
                    if (split) begin
                        o_stall  = 1'b1;
                        state_d  = SECOND;
                        latch_en = 1'b1;
                    end else begin
                        o_done = 1'b1;
                    end
                end
            end
        end
    end

    // State register and latched copy of a split request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            f3_q     <= 3'd0;
            we_q     <= 1'b0;
            off_q    <= 2'd0;
            w_q      <= 16'd0;
            wdata_q  <= 32'd0;
            lo_buf_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                f3_q    <= i_funct3;
                we_q    <= i_we;
                off_q   <= i_addr[1:0];
                w_q     <= i_addr[17:2];
                wdata_q <= i_wdata;
                if (!i_we)
                    lo_buf_q <= lo_buf_d;
            end
        end
    end

endmodule
